// File: rtl/pll_supervisor_pkg.sv
// Shared types and widths for the PLL lock supervisor.
// State encoding, debug count widths and a parameter helper.
package pll_supervisor_pkg;

   typedef enum logic [2:0] {
      PLL_RESET,
      WAIT_LOCK,
      STABLE,
      HOLD,
      RUN
   } state_t;

   localparam int LOSS_W  = 8;
   localparam int RETRY_W = 4;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_ff.sv
// Reset-to-0 multi-stage bit synchronizer.
// Reusable for any asynchronous single-bit input.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] s;

   // shift the async input through the flop chain
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s <= '0;
      end else begin
         s <= {s[STAGES-2:0], d};
      end
   end

   assign q = s[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Releases the PLL-domain reset once lock has been stable.
// Retries the PLL on lock timeout and counts lock losses.
module pll_lock_supervisor
   import pll_supervisor_pkg::*;
#(
   parameter int SYNC_STAGES         = 2,
   parameter int PLL_RST_CYCLES      = 8,
   parameter int LOCK_TIMEOUT_CYCLES = 1048576,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int RESET_HOLD_CYCLES   = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               pll_locked,
   output logic               pll_rst,
   output logic               rst_out,
   output logic               ready,
   output logic [LOSS_W-1:0]  lock_loss_count,
   output logic [RETRY_W-1:0] retry_count
);

   localparam int MAXP = max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES),
                              max2(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES));
   localparam int CW = $clog2(MAXP) + 1;

   localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD_CYCLES - 1);

   state_t        state, state_n;
   logic [CW-1:0] cnt;
   logic          locked_s;
   logic          retry_inc;
   logic          loss_inc;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clock (clock),
      .reset (reset),
      .d     (pll_locked),
      .q     (locked_s)
   );

   // next-state decode and count-increment strobes
   always_comb begin
      state_n   = state;
      retry_inc = 1'b0;
      loss_inc  = 1'b0;
      unique case (state)
         PLL_RESET: begin
            if (cnt == RST_LAST) state_n = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (locked_s) begin
               state_n = STABLE;
            end else if (cnt == TO_LAST) begin
               state_n   = PLL_RESET;
               retry_inc = 1'b1;
            end
         end
         STABLE: begin
            if (!locked_s)            state_n = WAIT_LOCK;
            else if (cnt == STB_LAST) state_n = HOLD;
         end
         HOLD: begin
            if (!locked_s)             state_n = WAIT_LOCK;
            else if (cnt == HOLD_LAST) state_n = RUN;
         end
         RUN: begin
            if (!locked_s) begin
               state_n  = WAIT_LOCK;
               loss_inc = 1'b1;
            end
         end
         default: state_n = PLL_RESET;
      endcase
   end

   // state register and shared cycle counter, cleared on every transition
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= PLL_RESET;
         cnt   <= '0;
      end else begin
         state <= state_n;
         if (state_n != state) cnt <= '0;
         else if (state != RUN) cnt <= cnt + CW'(1);
      end
   end

   // outputs registered from next state so they change with the state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pll_rst <= 1'b1;
         rst_out <= 1'b1;
         ready   <= 1'b0;
      end else begin
         pll_rst <= (state_n == PLL_RESET);
         rst_out <= (state_n != RUN);
         ready   <= (state_n == RUN);
      end
   end

   // saturating debug counters, only cleared by reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lock_loss_count <= '0;
         retry_count     <= '0;
      end else begin
         if (loss_inc && lock_loss_count != '1)
            lock_loss_count <= lock_loss_count + LOSS_W'(1);
         if (retry_inc && retry_count != '1)
            retry_count <= retry_count + RETRY_W'(1);
      end
   end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor.
// Table vectors for clean lock plus hand-written corner sequences.
module tb_pll_lock_supervisor;

   logic       clock;
   logic       reset;
   logic       pll_locked;
   logic       pll_rst;
   logic       rst_out;
   logic       ready;
   logic [7:0] lock_loss_count;
   logic [3:0] retry_count;

   int tests;
   int failed;
   int cyc;

   typedef struct {
      int   cyc;
      logic pll_rst;
      logic rst_out;
      logic ready;
   } vec_t;

   vec_t vecs[10];

   pll_lock_supervisor #(
      .SYNC_STAGES         (2),
      .PLL_RST_CYCLES      (3),
      .LOCK_TIMEOUT_CYCLES (64),
      .LOCK_STABLE_CYCLES  (8),
      .RESET_HOLD_CYCLES   (4)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .pll_locked      (pll_locked),
      .pll_rst         (pll_rst),
      .rst_out         (rst_out),
      .ready           (ready),
      .lock_loss_count (lock_loss_count),
      .retry_count     (retry_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic go_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d",
                  name, cyc, act, exp);
      end
   endtask

   task automatic do_reset(input logic lk);
      reset      = 1'b1;
      pll_locked = lk;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      cyc   = 0;
   endtask

   function automatic int sat(input int v, input int m);
      return (v > m) ? m : v;
   endfunction

   initial begin
      tests      = 0;
      failed     = 0;
      cyc        = 0;
      reset      = 1'b1;
      pll_locked = 1'b0;

      vecs[0] = '{0,  1'b1, 1'b1, 1'b0};
      vecs[1] = '{1,  1'b1, 1'b1, 1'b0};
      vecs[2] = '{2,  1'b1, 1'b1, 1'b0};
      vecs[3] = '{3,  1'b0, 1'b1, 1'b0};
      vecs[4] = '{4,  1'b0, 1'b1, 1'b0};
      vecs[5] = '{11, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{12, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{15, 1'b0, 1'b1, 1'b0};
      vecs[8] = '{16, 1'b0, 1'b0, 1'b1};
      vecs[9] = '{25, 1'b0, 1'b0, 1'b1};

      // clean lock
      do_reset(1'b1);
      for (int i = 0; i < 10; i++) begin
         go_to(vecs[i].cyc);
         chk("clean pll_rst", int'(pll_rst), int'(vecs[i].pll_rst));
         chk("clean rst_out", int'(rst_out), int'(vecs[i].rst_out));
         chk("clean ready",   int'(ready),   int'(vecs[i].ready));
      end
      chk("clean loss",  int'(lock_loss_count), 0);
      chk("clean retry", int'(retry_count), 0);

      // glitch in STABLE: low cycles 6..8, locked_s low 8..10
      do_reset(1'b1);
      go_to(6);
      pll_locked = 1'b0;
      go_to(9);
      pll_locked = 1'b1;
      go_to(16);
      chk("glitch ready@16", int'(ready), 0);
      go_to(23);
      chk("glitch ready@23", int'(ready), 0);
      chk("glitch rst_out@23", int'(rst_out), 1);
      go_to(24);
      chk("glitch ready@24", int'(ready), 1);
      chk("glitch rst_out@24", int'(rst_out), 0);
      chk("glitch loss", int'(lock_loss_count), 0);

      // loss in RUN for 20 cycles
      go_to(30);
      pll_locked = 1'b0;
      go_to(32);
      chk("loss rst_out@32", int'(rst_out), 0);
      chk("loss ready@32", int'(ready), 1);
      chk("loss count@32", int'(lock_loss_count), 0);
      go_to(33);
      chk("loss rst_out@33", int'(rst_out), 1);
      chk("loss ready@33", int'(ready), 0);
      chk("loss count@33", int'(lock_loss_count), 1);
      go_to(50);
      pll_locked = 1'b1;
      go_to(64);
      chk("relock ready@64", int'(ready), 0);
      go_to(65);
      chk("relock ready@65", int'(ready), 1);
      chk("relock count", int'(lock_loss_count), 1);

      // lock rises exactly on the timeout cycle
      do_reset(1'b0);
      go_to(64);
      pll_locked = 1'b1;
      go_to(66);
      chk("race pll_rst@66", int'(pll_rst), 0);
      go_to(67);
      chk("race pll_rst@67", int'(pll_rst), 0);
      chk("race retry", int'(retry_count), 0);
      go_to(78);
      chk("race ready@78", int'(ready), 0);
      go_to(79);
      chk("race ready@79", int'(ready), 1);

      // timeout retries, period 67, saturating at 15
      do_reset(1'b0);
      for (int k = 1; k <= 17; k++) begin
         go_to(67 * k - 1);
         chk("to pll_rst pre", int'(pll_rst), 0);
         chk("to retry pre", int'(retry_count), sat(k - 1, 15));
         go_to(67 * k);
         chk("to pll_rst on", int'(pll_rst), 1);
         chk("to retry", int'(retry_count), sat(k, 15));
         go_to(67 * k + 2);
         chk("to pll_rst end", int'(pll_rst), 1);
         chk("to rst_out", int'(rst_out), 1);
         go_to(67 * k + 3);
         chk("to pll_rst off", int'(pll_rst), 0);
      end

      // relock, then 260 RUN losses
      pll_locked = 1'b1;
      go_to(cyc + 100);
      chk("sat start ready", int'(ready), 1);
      for (int i = 1; i <= 260; i++) begin
         pll_locked = 1'b0;
         tick();
         pll_locked = 1'b1;
         go_to(cyc + 19);
         chk("sat ready", int'(ready), 1);
         chk("sat count", int'(lock_loss_count), sat(i, 255));
      end
      chk("sat retry kept", int'(retry_count), 15);

      // async reset mid-RUN, no clock edge in between
      #3;
      reset = 1'b1;
      #1;
      chk("areset rst_out", int'(rst_out), 1);
      chk("areset pll_rst", int'(pll_rst), 1);
      chk("areset ready", int'(ready), 0);
      chk("areset loss", int'(lock_loss_count), 0);
      chk("areset retry", int'(retry_count), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
